// File: rtl/sr_latch_bank.sv
// sr_latch_bank: bank of DEPTH set/reset registers with one write port,
// two registered read ports (with write-through bypass) and a clear-all
// sequencer that wipes one entry per clock.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | normal operation, set/reset writes accepted
// ST_SWEEP   | clearing entry[ptr] each edge, writes and clr_all ignored
module sr_latch_bank #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [WIDTH-1:0]  in,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              set,
    input  logic              reset,
    input  logic              clr_all,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [WIDTH-1:0]  out_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  out_b,
    output logic [DEPTH-1:0]  valid,
    output logic              busy
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SWEEP = 1'b1;

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    logic [0:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic              sweeping;
    logic              wr_en;
    logic [WIDTH-1:0]  wr_data;

    logic [WIDTH-1:0]  mem     [DEPTH];
    logic [WIDTH-1:0]  mem_nxt [DEPTH];
    logic [DEPTH-1:0]  valid_nxt;
    logic [WIDTH-1:0]  rd_a_nxt;
    logic [WIDTH-1:0]  rd_b_nxt;

    assign sweeping = (state == ST_SWEEP);
    assign busy     = sweeping;

    // Out-of-range write addresses simply match no entry below, so no
    // explicit range check is needed here. clr_all pre-empts a same-cycle write.
    assign wr_en   = !sweeping && !clr_all && (set || reset);
    assign wr_data = reset ? '0 : in;

    // Next contents of the bank: sweep clear, else accepted write, else hold.
    always_comb begin
        valid_nxt = valid;
        for (int i = 0; i < DEPTH; i++) begin
            mem_nxt[i] = mem[i];
            if (sweeping && (ptr == ADDR_W'(i))) begin
                mem_nxt[i]   = '0;
                valid_nxt[i] = 1'b0;
            end else if (wr_en && (wr_addr == ADDR_W'(i))) begin
                mem_nxt[i]   = wr_data;
                valid_nxt[i] = !reset;
            end
        end
    end

    // Read muxes look at next contents so same-edge updates bypass through;
    // addresses at or beyond DEPTH match nothing and read as zero.
    always_comb begin
        rd_a_nxt = '0;
        rd_b_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr_a == ADDR_W'(i)) rd_a_nxt = mem_nxt[i];
            if (rd_addr_b == ADDR_W'(i)) rd_b_nxt = mem_nxt[i];
        end
    end

    // Bank storage and valid flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= mem_nxt[i];
            valid <= valid_nxt;
        end
    end

    // Registered read ports.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_a <= '0;
            out_b <= '0;
        end else begin
            out_a <= rd_a_nxt;
            out_b <= rd_b_nxt;
        end
    end

    // Clear sequencer: one entry per edge, DEPTH edges, no restart while busy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            ptr   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clr_all) begin
                        state <= ST_SWEEP;
                        ptr   <= '0;
                    end
                end
                ST_SWEEP: begin
                    if (ptr == LAST_PTR) begin
                        state <= ST_IDLE;
                        ptr   <= '0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ptr   <= '0;
                end
            endcase
        end
    end

endmodule
